// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Requester ids index the one-hot gnt/rvalid/err vectors.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   typedef logic [1:0] id_t;

   localparam id_t ID_LOD = 2'd0;
   localparam id_t ID_DAT = 2'd1;
   localparam id_t ID_IFU = 2'd2;

   localparam int ADDR_W_D     = 32;
   localparam int DATA_W_D     = 32;
   localparam int MEM_AW_D     = 10;
   localparam int STARVE_LIM_D = 4;

   function automatic logic [2:0] id_onehot(id_t id);
      case (id)
         ID_LOD:  return 3'b001;
         ID_DAT:  return 3'b010;
         ID_IFU:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority winner select: lod > dat > ifu,
// except a starved ifu jumps to the front.
import mem_arb_pkg::*;

module mem_arb_pick (
   input  logic       lod_req,
   input  logic       dat_req,
   input  logic       ifu_req,
   input  logic       starve,
   output logic [1:0] id,
   output logic       valid
);

   always_comb begin
      id    = ID_LOD;
      valid = lod_req | dat_req | ifu_req;
      priority case (1'b1)
         (ifu_req && starve): id = ID_IFU;
         lod_req:             id = ID_LOD;
         dat_req:             id = ID_DAT;
         ifu_req:             id = ID_IFU;
         default:             id = ID_LOD;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for loader, data and fetch ports.
// Each access runs grant/memory cycle, then a response cycle for reads.
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int ADDR_W     = ADDR_W_D,
   parameter int DATA_W     = DATA_W_D,
   parameter int MEM_AW     = MEM_AW_D,
   parameter int STARVE_LIM = STARVE_LIM_D
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              lod_req,
   input  logic              lod_we,
   input  logic [ADDR_W-1:0] lod_addr,
   input  logic [DATA_W-1:0] lod_wdata,
   output logic              lod_gnt,
   output logic              lod_rvalid,
   output logic [DATA_W-1:0] lod_rdata,
   output logic              lod_err,

   input  logic              dat_req,
   input  logic              dat_we,
   input  logic [ADDR_W-1:0] dat_addr,
   input  logic [DATA_W-1:0] dat_wdata,
   output logic              dat_gnt,
   output logic              dat_rvalid,
   output logic [DATA_W-1:0] dat_rdata,
   output logic              dat_err,

   input  logic              ifu_req,
   input  logic              ifu_we,
   input  logic [ADDR_W-1:0] ifu_addr,
   input  logic [DATA_W-1:0] ifu_wdata,
   output logic              ifu_gnt,
   output logic              ifu_rvalid,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_err,

   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CW = $clog2(STARVE_LIM + 1);

   state_t            state;
   id_t               id_q;
   logic              we_q;
   logic              oor_q;
   logic [2:0]        gnt_q;
   logic [2:0]        rv_q;
   logic [2:0]        err_q;
   logic              en_q;
   logic              mwe_q;
   logic [CW-1:0]     starve_cnt;
   logic              starve;

   logic [1:0]        win_id;
   logic              win_vld;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_oor;
   logic              unused_bits;

   assign starve = (starve_cnt >= CW'(STARVE_LIM));

   mem_arb_pick u_pick (
      .lod_req (lod_req),
      .dat_req (dat_req),
      .ifu_req (ifu_req),
      .starve  (starve),
      .id      (win_id),
      .valid   (win_vld)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      unique case (win_id)
         ID_LOD: begin
            sel_we    = lod_we;
            sel_addr  = lod_addr;
            sel_wdata = lod_wdata;
         end
         ID_DAT: begin
            sel_we    = dat_we;
            sel_addr  = dat_addr;
            sel_wdata = dat_wdata;
         end
         ID_IFU: begin
            sel_we    = ifu_we;
            sel_addr  = ifu_addr;
            sel_wdata = ifu_wdata;
         end
         default: ;
      endcase
   end

   assign sel_oor     = |sel_addr[ADDR_W-1:MEM_AW+2];
   assign unused_bits = ^sel_addr[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         id_q      <= ID_LOD;
         we_q      <= 1'b0;
         oor_q     <= 1'b0;
         gnt_q     <= '0;
         rv_q      <= '0;
         err_q     <= '0;
         en_q      <= 1'b0;
         mwe_q     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         gnt_q <= '0;
         rv_q  <= '0;
         err_q <= '0;
         en_q  <= 1'b0;
         mwe_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_vld) begin
                  id_q  <= win_id;
                  we_q  <= sel_we;
                  oor_q <= sel_oor;
                  gnt_q <= id_onehot(win_id);
                  err_q <= sel_oor ? id_onehot(win_id) : 3'b000;
                  en_q  <= ~sel_oor;
                  mwe_q <= sel_we & ~sel_oor;
                  // RAM-side address/data only move for real accesses
                  if (!sel_oor) begin
                     mem_addr  <= sel_addr[MEM_AW+1:2];
                     mem_wdata <= sel_wdata;
                  end
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (we_q) begin
                  state <= IDLE;
               end else begin
                  rv_q  <= id_onehot(id_q);
                  state <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !ifu_req) begin
         starve_cnt <= '0;
      end else if (state == IDLE && win_vld) begin
         if (win_id == ID_IFU)
            starve_cnt <= '0;
         else if (!starve)
            starve_cnt <= starve_cnt + CW'(1);
      end
   end

   assign mem_en = en_q;
   // a write landing on a reset cycle must not reach the RAM
   assign mem_we = mwe_q & ~rst;

   assign lod_gnt    = gnt_q[0];
   assign dat_gnt    = gnt_q[1];
   assign ifu_gnt    = gnt_q[2];
   assign lod_err    = err_q[0];
   assign dat_err    = err_q[1];
   assign ifu_err    = err_q[2];
   assign lod_rvalid = rv_q[0];
   assign dat_rvalid = rv_q[1];
   assign ifu_rvalid = rv_q[2];

   assign lod_rdata = (rv_q[0] && !oor_q) ? mem_rdata : '0;
   assign dat_rdata = (rv_q[1] && !oor_q) ? mem_rdata : '0;
   assign ifu_rdata = (rv_q[2] && !oor_q) ? mem_rdata : '0;

endmodule
